// File: rtl/wisc_fetch_queue.sv
// Instruction-fetch front end: PC, credit-limited imem reads, and a DEPTH-entry
// instruction/PC FIFO with redirect flush and HLT drain. Optional WISC_FETCH_BYPASS_EN.
module wisc_fetch_queue #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       hlt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                inflight_q, inflight_d;
  logic                hlt_q, hlt_d;
  logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0]  fifo_instr_q [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc_q [DEPTH];

  logic          flush, ret_hlt, credit_ok, bypass, pop, fifo_pop, push, head_hlt;
  logic [CW-1:0] occ;

  always_comb begin
    occ       = wr_ptr_q - rd_ptr_q;
    flush     = redirect_valid && (state_q != S_HALTED);
    ret_hlt   = inflight_q && (imem_rdata[INSTR_W-1 -: 4] == 4'hF);
    credit_ok = (occ + CW'(inflight_q)) < CW'(DEPTH);
`ifdef WISC_FETCH_BYPASS_EN
    bypass    = inflight_q && (occ == '0) && !flush;
`else
    bypass    = 1'b0;
`endif

    instr_valid = bypass || (occ != '0);
    instr       = bypass ? imem_rdata : fifo_instr_q[rd_ptr_q[AW-1:0]];
    instr_pc    = bypass ? req_pc_q   : fifo_pc_q[rd_ptr_q[AW-1:0]];
    head_hlt    = instr[INSTR_W-1 -: 4] == 4'hF;

    pop      = instr_valid && instr_ready;
    fifo_pop = pop && (occ != '0);
    // A bypassed word taken by decode in its return cycle is never stored.
    push     = inflight_q && !flush && !(bypass && instr_ready);

    // The cycle an HLT returns must not issue the next sequential fetch.
    imem_req  = rst_n && (state_q == S_RUN) && credit_ok && !flush && !ret_hlt;
    imem_addr = pc_q;
    count     = occ;
    hlt       = hlt_q;

    pc_d = pc_q;
    if (flush) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
    req_pc_d   = imem_req ? pc_q : req_pc_q;
    inflight_d = imem_req;

    wr_ptr_d = flush ? '0 : wr_ptr_q + CW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + CW'(fifo_pop);

    state_d = state_q;
    hlt_d   = hlt_q;
    if (flush) begin
      state_d = S_RUN;
    end else if (pop && head_hlt) begin
      state_d = S_HALTED;
      hlt_d   = 1'b1;
    end else if ((state_q == S_RUN) && ret_hlt) begin
      state_d = S_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      hlt_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      hlt_q      <= hlt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q[AW-1:0]] <= imem_rdata;
      fifo_pc_q[wr_ptr_q[AW-1:0]]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_wisc_fetch_queue.sv
// Directed bench for wisc_fetch_queue; latency expectations follow WISC_FETCH_BYPASS_EN.
module tb_wisc_fetch_queue;

`ifdef WISC_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [2:0]  count;
  logic        hlt;

  logic [15:0] mem_addr_q;
  logic        hlt_en;
  logic [15:0] hlt_addr;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_req;

  wisc_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .count(count), .hlt(hlt)
  );

  always #5 clk = ~clk;

  // Instruction memory: word(a) = 0x1123 + (a/2)*0x1333, with any stray 0xF opcode
  // turned into 0xE so only the planted HLT halts the core.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic en,
                                           input logic [15:0] ha);
    logic [15:0] w;
    if (en && a == ha) return 16'hF000;
    w = 16'h1123 + 16'((a >> 1) * 16'h1333);
    if (w[15:12] == 4'hF) w[15:12] = 4'hE;
    return w;
  endfunction

  always @(posedge clk) mem_addr_q <= imem_addr;
  assign imem_rdata = mem_word(mem_addr_q, hlt_en, hlt_addr);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rst_req",   32'(imem_req),    32'd0);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_count", 32'(count),       32'd0);
    check_val("rst_hlt",   32'(hlt),         32'd0);
  endtask

  logic [15:0] t1_words [7];
  logic [15:0] t3_words [3];

  initial begin
    t1_words = '{16'h1123, 16'h2456, 16'h3789, 16'h4ABC, 16'h5DEF, 16'h7122, 16'h8455};
    t3_words = '{16'h7783, 16'h8AB6, 16'h9DE9};
    hlt_en   = 1'b0;
    hlt_addr = 16'h0006;

    // Sequential fetch with decode always ready.
    do_reset();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      $display("t1 cyc %0d req=%0d addr=%h valid=%0d instr=%h pc=%h", k, imem_req, imem_addr, instr_valid, instr, instr_pc);
      check_val("t1_req", 32'(imem_req), 32'd1);
      check_val("t1_addr", 32'(imem_addr), 32'(2 * k));
      if (k < LAT) check_val("t1_valid0", 32'(instr_valid), 32'd0);
      else begin
        check_val("t1_valid", 32'(instr_valid), 32'd1);
        check_val("t1_instr", 32'(instr), 32'(t1_words[k-LAT]));
        check_val("t1_pc", 32'(instr_pc), 32'(2 * (k - LAT)));
      end
      if (k == 3) check_val("t1_count", 32'(count), (LAT == 2) ? 32'd1 : 32'd0);
    end

    // Credit limit with decode stalled.
    do_reset();
    rst_n = 1'b1;
    n_req = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_req += int'(imem_req);
    end
    $display("t2 stalled requests=%0d count=%0d", n_req, count);
    check_val("t2_nreq", 32'(n_req), 32'd4);
    check_val("t2_count", 32'(count), 32'd4);
    check_val("t2_req_held", 32'(imem_req), 32'd0);
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    check_val("t2_pop_instr", 32'(instr), 32'h1123);
    check_val("t2_pop_pc", 32'(instr_pc), 32'h0000);
    check_val("t2_pop_req", 32'(imem_req), 32'd0);
    n_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      n_req += int'(imem_req);
    end
    $display("t2 after one pop requests=%0d count=%0d", n_req, count);
    check_val("t2_one_req", 32'(n_req), 32'd1);
    check_val("t2_refill", 32'(count), 32'd4);

    // Redirect while a word is returning.
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      redirect_valid = (k == 1);
      redirect_pc    = 16'h0040;
      instr_ready    = (k >= 2);
      #1;
      $display("t3 cyc %0d req=%0d addr=%h valid=%0d instr=%h pc=%h count=%0d", k, imem_req, imem_addr, instr_valid, instr, instr_pc, count);
      if (k == 1) check_val("t3_drop_valid", 32'(instr_valid), 32'd0);
      if (k == 2) begin
        check_val("t3_count", 32'(count), 32'd0);
        check_val("t3_req", 32'(imem_req), 32'd1);
        check_val("t3_addr", 32'(imem_addr), 32'h0040);
      end
      if (k >= 2 && k < 2 + LAT) check_val("t3_valid0", 32'(instr_valid), 32'd0);
      if (k >= 2 + LAT) begin
        check_val("t3_pc", 32'(instr_pc), 32'(16'h0040 + 16'(2 * (k - 2 - LAT))));
        check_val("t3_instr", 32'(instr), 32'(t3_words[k-2-LAT]));
      end
    end

    // HLT at 0x0006, decode ready: halts, then ignores redirect.
    do_reset();
    hlt_en = 1'b1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      redirect_valid = (k == 8);
      redirect_pc    = 16'h0010;
      #1;
      $display("t4 cyc %0d req=%0d addr=%h valid=%0d instr=%h pc=%h hlt=%0d", k, imem_req, imem_addr, instr_valid, instr, instr_pc, hlt);
      if (k <= 3) begin
        check_val("t4_req", 32'(imem_req), 32'd1);
        check_val("t4_addr", 32'(imem_addr), 32'(2 * k));
      end else check_val("t4_noreq", 32'(imem_req), 32'd0);
      if (k == 3 + LAT) begin
        check_val("t4_hlt_instr", 32'(instr), 32'hF000);
        check_val("t4_hlt_pc", 32'(instr_pc), 32'h0006);
        check_val("t4_hlt_early", 32'(hlt), 32'd0);
      end
      if (k >= 4 + LAT) check_val("t4_hlt", 32'(hlt), 32'd1);
      if (k == 9) check_val("t4_valid", 32'(instr_valid), 32'd0);
    end

    // HLT buffered in DRAIN; redirect in the cycle it is consumed wins.
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      instr_ready    = (k >= 5 && k <= 8) || (k >= 10);
      redirect_valid = (k == 8);
      redirect_pc    = 16'h0010;
      #1;
      $display("t5 cyc %0d req=%0d addr=%h valid=%0d instr=%h pc=%h count=%0d hlt=%0d", k, imem_req, imem_addr, instr_valid, instr, instr_pc, count, hlt);
      if (k == 4) check_val("t5_noreq", 32'(imem_req), 32'd0);
      if (k >= 5 && k <= 7) check_val("t5_drain_pc", 32'(instr_pc), 32'(2 * (k - 5)));
      if (k == 8) begin
        check_val("t5_head_instr", 32'(instr), 32'hF000);
        check_val("t5_head_pc", 32'(instr_pc), 32'h0006);
      end
      if (k == 9) begin
        check_val("t5_hlt", 32'(hlt), 32'd0);
        check_val("t5_count", 32'(count), 32'd0);
        check_val("t5_req", 32'(imem_req), 32'd1);
        check_val("t5_addr", 32'(imem_addr), 32'h0010);
      end
      if (k == 9 + LAT) begin
        check_val("t5_new_pc", 32'(instr_pc), 32'h0010);
        check_val("t5_new_instr", 32'(instr), 32'hAABB);
        check_val("t5_hlt_late", 32'(hlt), 32'd0);
      end
    end

    // PC wrap at 0xFFFE.
    do_reset();
    hlt_en = 1'b0;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      redirect_valid = (k == 0);
      redirect_pc    = 16'hFFFE;
      #1;
      $display("t6 cyc %0d req=%0d addr=%h valid=%0d instr=%h pc=%h count=%0d", k, imem_req, imem_addr, instr_valid, instr, instr_pc, count);
      if (k == 1) check_val("t6_addr_top", 32'(imem_addr), 32'hFFFE);
      if (k == 2) check_val("t6_addr_wrap", 32'(imem_addr), 32'h0000);
      if (k == 1 + LAT) begin
        check_val("t6_pc_top", 32'(instr_pc), 32'hFFFE);
        check_val("t6_instr_top", 32'(instr), 32'h7DF0);
      end
      if (k == 2 + LAT) begin
        check_val("t6_pc_wrap", 32'(instr_pc), 32'h0000);
        check_val("t6_instr_wrap", 32'(instr), 32'h1123);
      end
      if (k == 3) check_val("t6_count", 32'(count), (LAT == 2) ? 32'd1 : 32'd0);
    end

    // Reset mid-operation clears everything again.
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wisc_fetch_queue.md
# wisc_fetch_queue

Parametrised instruction-fetch front end for the WISC pipelined core. It sits between instruction memory and the decode stage and replaces the direct PC-to-memory path. It holds a PC register, issues one instruction-memory read per cycle under a credit limit, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It also flushes on branch redirect and stops fetching at the first HLT (opcode 4'hF), raising `hlt` once that HLT is consumed by decode.

## Interface
- `ADDR_W`, 16: PC / instruction-memory address width.
- `INSTR_W`, 16: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PC_STEP`, 2: PC increment per sequential fetch (byte-addressed).
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out ADDR_W: read address, valid when `imem_req`=1.
- `imem_rdata` in INSTR_W: read data, valid exactly one cycle after the `imem_req` cycle.
- `redirect_valid` in 1: branch/flush request.
- `redirect_pc` in ADDR_W: new fetch PC.
- `instr_valid` out 1: FIFO head valid.
- `instr_ready` in 1: decode accepts head; a transfer occurs when `instr_valid`&`instr_ready`.
- `instr` out INSTR_W: head instruction.
- `instr_pc` out ADDR_W: PC of head instruction.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `hlt` out 1: sticky; HLT has been consumed.

## Operation
- State machine:
  - RUN: fetching.
  - DRAIN: HLT fetched, no further requests.
  - HALTED: `hlt`=1, no requests, redirects ignored.
- `imem_req`=1 only in RUN, and only when `count + inflight < DEPTH`. `inflight` is 1 if a request was issued the previous cycle and not cancelled.
- `imem_addr`=`pc`. On each request, `pc <= pc + PC_STEP` (modulo 2^ADDR_W; 0xFFFE wraps to 0x0000).
- A returning word is pushed together with its request address. If its opcode is 4'hF, the state goes RUN→DRAIN in the same edge.
- Redirect (RUN or DRAIN):
  - FIFO is cleared, `inflight` cancelled, and the returning word (if any) dropped.
  - `pc <= redirect_pc`; state → RUN.
  - The first request to `redirect_pc` is made in the next cycle.
  - A transfer in the redirect cycle still counts as consumed.
- A transfer of an HLT entry moves the state to HALTED and sets `hlt`=1 from the next cycle.
- If redirect and an HLT transfer occur in the same cycle, redirect wins: the state goes to RUN and `hlt` stays 0.
- Push and pop in the same cycle when full cannot occur, because the credit rule prevents overflow. Push and pop in the same cycle when non-empty leaves `count` unchanged.
- Pop when empty is ignored.

## Timing
- During reset: `imem_req`=0, `instr_valid`=0, `count`=0, `hlt`=0, `pc`=RESET_PC, state RUN, `inflight`=0.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=RESET_PC.
- Fetch-to-decode latency is 2 cycles: the request in cycle N is pushed at the end of N+1, and `instr_valid` is visible in N+2.
- Steady state with decode always ready: one instruction per cycle.
- Redirect in cycle N: request to `redirect_pc` in N+1, instruction at decode in N+3.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and any in-flight return is discarded.

## Configuration
- `WISC_FETCH_BYPASS_EN`:
  - When defined: a word returning into an empty FIFO with no redirect is driven combinationally on `instr`/`instr_pc`/`instr_valid` in its return cycle, giving a fetch-to-decode latency of 1. If `instr_ready`=1 in that cycle it is consumed and not stored; otherwise it is stored normally.
  - When undefined: no bypass, and latency is 2 as stated in Timing.

## Test plan
- Reset release, memory returning 0x1123, 0x2456, ..., decode always ready → `imem_addr` 0x0000, 0x0002, 0x0004...; `instr` 0x1123 with `instr_pc`=0x0000 two cycles after the first request, then one per cycle.
- DEPTH=4, `instr_ready`=0 → exactly 4 requests issued; `count`=4; `imem_req` held 0; raising ready for one cycle allows exactly one new request.
- Redirect to 0x0040 in the same cycle an in-flight word returns → word dropped; `count`=0 next cycle; next `imem_addr`=0x0040; first `instr_pc` after the flush=0x0040.
- 0xF000 fetched at 0x0006 → no request after the one at 0x0006; `hlt` rises the cycle after 0x0006 is consumed and stays 1; a later redirect is ignored.
- HLT in DRAIN, then redirect to 0x0010 before it is consumed → state RUN, `hlt` stays 0, fetching resumes at 0x0010.
- PC at 0xFFFE → next `imem_addr`=0x0000; with `WISC_FETCH_BYPASS_EN` defined, an empty FIFO with ready asserted shows the instruction in its return cycle.
